// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the gate truth checker.
package gate_chk_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } chk_state_t;

  // Expected-output tables; bit i is the expected Y for input vector i.
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [7:0] TT_OR3   = 8'hFE;

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// Settle timer: counts cycles a vector has been held and flags when the
// final settle cycle has been reached.
module gate_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  // Count held cycles; stop at the last settle cycle so the value never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Gate truth checker: sweeps every input vector into a small combinational
// gate, waits a settle time, samples Y against a truth table and reports
// error count, first failing vector and pass/fail.
module gate_truth_checker #(
  parameter int                 N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b1110,
  parameter int                 SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            Y,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  // Only the type is imported: the state literal SETTLE would otherwise be
  // shadowed by the SETTLE parameter, so literals are package-scoped below.
  import gate_chk_pkg::chk_state_t;

  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  chk_state_t    state;
  logic          expired;
  logic          timer_clr;
  logic          timer_en;
  logic          mismatch;
  logic [N_IN:0] err_next;

  // Timer runs only while a vector settles; any other state leaves it cleared
  // so each new vector starts counting from zero.
  assign timer_en  = (state == gate_chk_pkg::SETTLE);
  assign timer_clr = (state != gate_chk_pkg::SETTLE);

  assign mismatch = (state == gate_chk_pkg::SAMPLE) && (Y != TRUTH[vec]);
  assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

  gate_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  // Sweep sequencer with vector and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= gate_chk_pkg::IDLE;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        gate_chk_pkg::IDLE,
        gate_chk_pkg::DONE: begin
          if (start) begin
            state          <= gate_chk_pkg::SETTLE;
            vec            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        gate_chk_pkg::SETTLE: begin
          if (expired) begin
            state <= gate_chk_pkg::SAMPLE;
          end
        end
        gate_chk_pkg::SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            first_fail_vec <= vec;
            fail_valid     <= 1'b1;
          end
          // The final verdict must include this cycle's compare.
          if (vec == LAST_VEC) begin
            state <= gate_chk_pkg::DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            vec   <= vec + N_IN'(1);
            state <= gate_chk_pkg::SETTLE;
          end
        end
        default: begin
          state <= gate_chk_pkg::IDLE;
        end
      endcase
    end
  end

endmodule
